// File: rtl/bist_pkg.sv
// bist_pkg: shared pattern, LFSR and FSM encodings for the RAM self-test engine.
package bist_pkg;

  typedef enum logic [1:0] {
    PAT_ADDR  = 2'd0,
    PAT_NADDR = 2'd1,
    PAT_CHK   = 2'd2,
    PAT_LFSR  = 2'd3
  } pat_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } bist_state_t;

endpackage

// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: expected/write data for the current word address.
// The LFSR steps once per completed access and is reseeded per pass.
module bist_pattern_gen
  import bist_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        seed,
  input  logic        advance,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] addr,
  output logic [15:0] data
);

  logic [15:0] lfsr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lfsr <= LFSR_SEED;
    end else if (seed) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end
  end

  always_comb begin
    data = addr;
    unique case (pat_t'(pattern_sel))
      PAT_ADDR:  data = addr;
      PAT_NADDR: data = ~addr;
      PAT_CHK:   data = addr[0] ? 16'hAAAA : 16'h5555;
      PAT_LFSR:  data = lfsr;
      default:   data = addr;
    endcase
  end

endmodule

// File: rtl/ram_bist.sv
// ram_bist: write-then-readback self-test master for the ram_ctrl request port.
// Optional RAM_BIST_STOP_ON_ERR_EN ends the test at the first mismatch.
module ram_bist
  import bist_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] ADDR_LAST = 23'h7FFFFF,
  parameter int TIMEOUT = 1023
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  bist_state_t       state;
  logic [1:0]        patSel;
  logic [ADDR_W-1:0] addr;
  logic [WCW-1:0]    waitCnt;
  logic [15:0]       errCnt;
  logic [ADDR_W-1:0] failAddr;
  logic [DATA_W-1:0] failData;
  logic              busyR, doneR, passR, toR, reqR, weR;
  logic [DATA_W-1:0] patData;
  logic              last, idleLike, inWait, seed, advance;
  logic              mismatch, stopNow;

  assign last     = addr == ADDR_LAST;
  assign idleLike = state == ST_IDLE || state == ST_DONE;
  assign inWait   = state == ST_WR_WAIT || state == ST_RD_WAIT;
  assign seed     = (start && idleLike)
                  || (mem_rdy && state == ST_WR_WAIT && last);
  assign advance  = mem_rdy && inWait && !last;
  assign mismatch = mem_rdy && state == ST_RD_WAIT
                  && mem_rdata != patData;

`ifdef RAM_BIST_STOP_ON_ERR_EN
  assign stopNow = mismatch;
`else
  assign stopNow = 1'b0;
`endif

  bist_pattern_gen uGen (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .seed        (seed),
    .advance     (advance),
    .pattern_sel (patSel),
    .addr        (addr[15:0]),
    .data        (patData)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      patSel   <= '0;
      addr     <= '0;
      waitCnt  <= '0;
      errCnt   <= '0;
      failAddr <= '0;
      failData <= '0;
      busyR    <= 1'b0;
      doneR    <= 1'b0;
      passR    <= 1'b0;
      toR      <= 1'b0;
      reqR     <= 1'b0;
      weR      <= 1'b0;
    end else begin
      reqR <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            patSel   <= pattern_sel;
            errCnt   <= '0;
            failAddr <= '0;
            failData <= '0;
            toR      <= 1'b0;
            passR    <= 1'b0;
            doneR    <= 1'b0;
            busyR    <= 1'b1;
            addr     <= '0;
            reqR     <= 1'b1;
            weR      <= 1'b1;
            state    <= ST_WR_REQ;
          end
        end
        ST_WR_REQ, ST_RD_REQ: begin
          waitCnt <= '0;
          state   <= (state == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
        end
        ST_WR_WAIT, ST_RD_WAIT: begin
          if (mem_rdy) begin
            if (mismatch) begin
              if (errCnt != 16'hFFFF) errCnt <= errCnt + 16'd1;
              if (errCnt == 16'd0) begin
                failAddr <= addr;
                failData <= mem_rdata;
              end
            end
            if (state == ST_RD_WAIT && (last || stopNow)) begin
              busyR <= 1'b0;
              doneR <= 1'b1;
              passR <= !mismatch && errCnt == 16'd0;
              state <= ST_DONE;
            end else if (state == ST_WR_WAIT && last) begin
              addr  <= '0;
              reqR  <= 1'b1;
              weR   <= 1'b0;
              state <= ST_RD_REQ;
            end else begin
              addr  <= addr + 1'b1;
              reqR  <= 1'b1;
              state <= (state == ST_WR_WAIT) ? ST_WR_REQ : ST_RD_REQ;
            end
          end else if (waitCnt == WCW'(TIMEOUT - 1)) begin
            toR   <= 1'b1;
            busyR <= 1'b0;
            doneR <= 1'b1;
            passR <= 1'b0;
            weR   <= 1'b0;
            state <= ST_DONE;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busyR;
  assign done      = doneR;
  assign pass      = passR;
  assign timeout   = toR;
  assign err_cnt   = errCnt;
  assign fail_addr = failAddr;
  assign fail_data = failData;
  assign mem_req   = reqR;
  assign mem_we    = weR;
  assign mem_addr  = {{(32 - ADDR_W){1'b0}}, addr};
  assign mem_wdata = weR ? patData : '0;

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: directed checks of ram_bist against a small RAM model
// with a 16-word range and a 15-cycle timeout.
module tb_ram_bist;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [1:0]  pattern_sel;
  logic        busy, done, pass, timeout;
  logic [15:0] err_cnt;
  logic [22:0] fail_addr;
  logic [15:0] fail_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_rdy = 1'b0;

  always #10 clk = ~clk;

  ram_bist #(
    .ADDR_W    (23),
    .DATA_W    (16),
    .ADDR_LAST (23'd15),
    .TIMEOUT   (15)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .pattern_sel (pattern_sel),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .err_cnt     (err_cnt),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rdy     (mem_rdy)
  );

  // RAM model: completes each request two cycles after mem_req
  logic [15:0] mem   [16];
  logic [15:0] wrLog [16];
  logic [3:0]  reqAddr;
  logic        reqWe;
  logic [15:0] reqData;
  logic        pend = 1'b0;
  logic        rdyEn = 1'b1;
  int          corruptAddr = -1;
  logic [15:0] corruptVal = 16'h0004;
  int          wrCnt = 0;
  int          rdCnt = 0;
  int          reqInRst = 0;

  always @(posedge clk) begin
    mem_rdy <= 1'b0;
    if (sys_rst) begin
      pend <= 1'b0;
      if (mem_req === 1'b1) reqInRst <= reqInRst + 1;
    end else if (mem_req) begin
      pend    <= 1'b1;
      reqAddr <= mem_addr[3:0];
      reqWe   <= mem_we;
      reqData <= mem_wdata;
      if (mem_we) wrCnt <= wrCnt + 1;
      else rdCnt <= rdCnt + 1;
    end else if (pend && rdyEn) begin
      pend    <= 1'b0;
      mem_rdy <= 1'b1;
      if (reqWe) begin
        mem[reqAddr]   <= reqData;
        wrLog[reqAddr] <= reqData;
      end else begin
        mem_rdata <= (int'(reqAddr) == corruptAddr) ? corruptVal
                                                    : mem[reqAddr];
      end
    end
  end

  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulseStart(input logic [1:0] sel);
    @(negedge clk);
    start       = 1'b1;
    pattern_sel = sel;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int maxCyc);
    int n = 0;
    while (!done && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", {31'd0, done}, 32'd1);
  endtask

  int base;
  int bad;
  int n;

  initial begin
    sys_rst     = 1'b1;
    start       = 1'b1;
    pattern_sel = 2'd0;

    // 1: reset with start held high
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass_to", {30'd0, pass, timeout}, 32'd0);
    check("rst_err", {16'd0, err_cnt}, 32'd0);
    check("rst_fail", {9'd0, fail_addr} | {16'd0, fail_data}, 32'd0);
    check("rst_mem", {30'd0, mem_req, mem_we} | mem_addr
                     | {16'd0, mem_wdata}, 32'd0);
    start   = 1'b0;
    sys_rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_noreq", reqInRst, 0);
    check("idle_noreq", {31'd0, mem_req}, 32'd0);

    // 2: address pattern, clean memory
    base = wrCnt;
    pulseStart(2'd0);
    check("busy_run", {31'd0, busy}, 32'd1);
    waitDone(500);
    check("p0_wrcnt", wrCnt - base, 16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (wrLog[i] !== 16'(i)) bad++;
    check("p0_wdata", bad, 0);
    check("p0_pass", {31'd0, pass}, 32'd1);
    check("p0_err", {16'd0, err_cnt}, 32'd0);
    check("p0_busy", {31'd0, busy}, 32'd0);

    // 3: corrupted read at address 5
    corruptAddr = 5;
    base = rdCnt;
    pulseStart(2'd0);
    waitDone(500);
    check("c_err", {16'd0, err_cnt}, 32'd1);
    check("c_faddr", {9'd0, fail_addr}, 32'd5);
    check("c_fdata", {16'd0, fail_data}, 32'h0004);
    check("c_pass", {31'd0, pass}, 32'd0);
`ifdef RAM_BIST_STOP_ON_ERR_EN
    check("c_rdcnt", rdCnt - base, 6);
`else
    check("c_rdcnt", rdCnt - base, 16);
`endif
    corruptAddr = -1;

    // 4: LFSR, inverted address and checkerboard patterns
    pulseStart(2'd3);
    waitDone(500);
    check("l_w0", {16'd0, wrLog[0]}, 32'hACE1);
    check("l_w1", {16'd0, wrLog[1]}, 32'hE270);
    check("l_w2", {16'd0, wrLog[2]}, 32'h7138);
    check("l_w3", {16'd0, wrLog[3]}, 32'h389C);
    check("l_pass", {31'd0, pass}, 32'd1);
    check("l_err", {16'd0, err_cnt}, 32'd0);
    pulseStart(2'd1);
    waitDone(500);
    check("n_w3", {16'd0, wrLog[3]}, 32'hFFFC);
    check("n_w15", {16'd0, wrLog[15]}, 32'hFFF0);
    check("n_pass", {31'd0, pass}, 32'd1);
    pulseStart(2'd2);
    waitDone(500);
    check("k_w0", {16'd0, wrLog[0]}, 32'h5555);
    check("k_w1", {16'd0, wrLog[1]}, 32'hAAAA);
    check("k_pass", {31'd0, pass}, 32'd1);

    // 5: no mem_rdy ever
    rdyEn = 1'b0;
    pulseStart(2'd0);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t_req", {31'd0, mem_req}, 32'd1);
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t_lat", {31'd0, n <= 17}, 32'd1);
    check("t_flag", {31'd0, timeout}, 32'd1);
    check("t_done", {31'd0, done}, 32'd1);
    check("t_pass", {31'd0, pass}, 32'd0);
    rdyEn = 1'b1;
    repeat (4) @(negedge clk);
    check("t_hold", {30'd0, done, busy}, 32'd2);

    // 6: start during write is ignored
    base = wrCnt;
    pulseStart(2'd0);
    check("s_clr_to", {31'd0, timeout}, 32'd0);
    repeat (10) @(negedge clk);
    start       = 1'b1;
    pattern_sel = 2'd3;
    @(negedge clk);
    start = 1'b0;
    check("s_busy", {31'd0, busy}, 32'd1);
    waitDone(500);
    check("s_wrcnt", wrCnt - base, 16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (wrLog[i] !== 16'(i)) bad++;
    check("s_wdata", bad, 0);
    check("s_pass", {31'd0, pass}, 32'd1);

    // 6b: reset in the read pass, then a fresh run
    base = rdCnt;
    pulseStart(2'd0);
    n = 0;
    while (rdCnt - base < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("r_inread", {31'd0, rdCnt - base >= 3}, 32'd1);
    sys_rst = 1'b1;
    @(negedge clk);
    check("r_busy", {31'd0, busy}, 32'd0);
    check("r_req", {31'd0, mem_req}, 32'd0);
    sys_rst = 1'b0;
    pulseStart(2'd2);
    waitDone(500);
    check("r_pass", {31'd0, pass}, 32'd1);
    check("r_err", {16'd0, err_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
